// File: rtl/pulse_event_counter_pkg.sv
// Shared constants and helpers for the pulse event counter slice.
package pulse_event_counter_pkg;

    localparam int unsigned DEFAULT_CNT_WIDTH = 16;

    function automatic logic is_rising(input logic level, input logic level_d);
        return level & ~level_d;
    endfunction

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector for a level that is already in the CLK domain.
// EDGE_OUT is combinational from one flop so a consumer can act on the same edge.
module pulse_edge_detect
    import pulse_event_counter_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic LEVEL_IN,
    output logic EDGE_OUT
);

    logic pulse_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pulse_d <= 1'b0;
        end else begin
            pulse_d <= LEVEL_IN;
        end
    end

    assign EDGE_OUT = is_rising(LEVEL_IN, pulse_d);

endmodule

// File: rtl/pulse_event_counter.sv
// Saturating event counter with sticky overflow and a four-phase snapshot port.
// The registered EVENT strobe lives here so it updates on the same edge as COUNT.
module pulse_event_counter
    import pulse_event_counter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = DEFAULT_CNT_WIDTH,
    parameter logic        CLEAR_ON_SNAP = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 PULSE_IN,
    input  logic                 CLEAR,
    input  logic                 SNAP_REQ,
    output logic                 SNAP_ACK,
    output logic [CNT_WIDTH-1:0] SNAP_COUNT,
    output logic [CNT_WIDTH-1:0] COUNT,
    output logic                 OVERFLOW,
    output logic                 EVENT
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [0:0]           state;
    logic [0:0]           state_next;
    logic                 pulse_edge;
    logic                 snap_take;
    logic                 restart;
    logic [CNT_WIDTH-1:0] count_next;
    logic [CNT_WIDTH-1:0] snap_next;
    logic                 overflow_next;

    pulse_edge_detect u_edge (
        .CLK      (CLK),
        .RST      (RST),
        .LEVEL_IN (PULSE_IN),
        .EDGE_OUT (pulse_edge)
    );

    always_comb begin
        snap_take     = (state == IDLE) && SNAP_REQ;
        restart       = CLEAR || (CLEAR_ON_SNAP && snap_take);
        count_next    = COUNT;
        overflow_next = OVERFLOW;
        if (restart) begin
            count_next    = '0;
            count_next[0] = pulse_edge;
            overflow_next = 1'b0;
        end else if (pulse_edge) begin
            if (COUNT == COUNT_MAX) begin
                overflow_next = 1'b1;
            end else begin
                count_next = COUNT + 1'b1;
            end
        end
        // In clear-on-snap mode a concurrent edge opens the next window, so the
        // capture takes the pre-edge count; otherwise it takes the next count.
        snap_next = CLEAR_ON_SNAP ? COUNT : count_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (SNAP_REQ)  state_next = ACK;
            ACK:     if (!SNAP_REQ) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            EVENT      <= 1'b0;
            COUNT      <= '0;
            OVERFLOW   <= 1'b0;
            SNAP_COUNT <= '0;
        end else begin
            state    <= state_next;
            EVENT    <= pulse_edge;
            COUNT    <= count_next;
            OVERFLOW <= overflow_next;
            if (snap_take) begin
                SNAP_COUNT <= snap_next;
            end
        end
    end

    assign SNAP_ACK = (state == ACK);

endmodule

// File: tb/tb_pulse_event_counter.sv
// Bench driving three counter configurations from shared inputs against an
// event-level reference model.
module tb_pulse_event_counter;

    logic CLK = 1'b0;
    logic RST, PULSE_IN, CLEAR, SNAP_REQ;

    logic        a_ack, a_ovf, a_ev;
    logic [15:0] a_snap, a_cnt;
    logic        b_ack, b_ovf, b_ev;
    logic [3:0]  b_snap, b_cnt;
    logic        c_ack, c_ovf, c_ev;
    logic [15:0] c_snap, c_cnt;

    int checks = 0;
    int failures = 0;

    pulse_event_counter dut_a (
        .CLK(CLK), .RST(RST), .PULSE_IN(PULSE_IN), .CLEAR(CLEAR), .SNAP_REQ(SNAP_REQ),
        .SNAP_ACK(a_ack), .SNAP_COUNT(a_snap), .COUNT(a_cnt), .OVERFLOW(a_ovf), .EVENT(a_ev)
    );

    pulse_event_counter #(.CNT_WIDTH(4)) dut_b (
        .CLK(CLK), .RST(RST), .PULSE_IN(PULSE_IN), .CLEAR(CLEAR), .SNAP_REQ(SNAP_REQ),
        .SNAP_ACK(b_ack), .SNAP_COUNT(b_snap), .COUNT(b_cnt), .OVERFLOW(b_ovf), .EVENT(b_ev)
    );

    pulse_event_counter #(.CNT_WIDTH(16), .CLEAR_ON_SNAP(1'b1)) dut_c (
        .CLK(CLK), .RST(RST), .PULSE_IN(PULSE_IN), .CLEAR(CLEAR), .SNAP_REQ(SNAP_REQ),
        .SNAP_ACK(c_ack), .SNAP_COUNT(c_snap), .COUNT(c_cnt), .OVERFLOW(c_ovf), .EVENT(c_ev)
    );

    always #5 CLK = ~CLK;

    // Reference model: events counted per window, capped at the width limit.
    int unsigned m_width[3] = '{16, 4, 16};
    bit          m_cos[3]   = '{1'b0, 1'b0, 1'b1};
    int unsigned m_cnt[3], m_snap[3];
    bit          m_ovf[3], m_ack[3], m_ev[3];
    bit          m_prev;

    task automatic model_reset();
        m_prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_snap[i] = 0; m_ovf[i] = 1'b0; m_ack[i] = 1'b0; m_ev[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit new_event, take, restart;
        int unsigned limit, ncnt;
        if (RST) begin
            model_reset();
            return;
        end
        new_event = PULSE_IN && !m_prev;
        m_prev = PULSE_IN;
        for (int i = 0; i < 3; i++) begin
            limit   = (1 << m_width[i]) - 1;
            take    = !m_ack[i] && SNAP_REQ;
            restart = CLEAR || (m_cos[i] && take);
            ncnt    = restart ? 32'(new_event) : ((m_cnt[i] + new_event > limit) ? limit : m_cnt[i] + new_event);
            m_ovf[i] = restart ? 1'b0 : (m_ovf[i] || (new_event && m_cnt[i] == limit));
            if (take) m_snap[i] = m_cos[i] ? m_cnt[i] : ncnt;
            m_ack[i] = SNAP_REQ;
            m_ev[i]  = new_event;
            m_cnt[i] = ncnt;
        end
    endtask

    function automatic logic [34:0] obs(input int i);
        case (i)
            0:       return {a_ev, a_ovf, a_ack, a_snap, a_cnt};
            1:       return {b_ev, b_ovf, b_ack, 12'h000, b_snap, 12'h000, b_cnt};
            default: return {c_ev, c_ovf, c_ack, c_snap, c_cnt};
        endcase
    endfunction

    function automatic logic [34:0] expv(input int i);
        return {m_ev[i], m_ovf[i], m_ack[i], m_snap[i][15:0], m_cnt[i][15:0]};
    endfunction

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic pulse_once(output int ev_a, output int ev_b);
        PULSE_IN = 1'b1; cycle();
        ev_a = int'(a_ev); ev_b = int'(b_ev);
        PULSE_IN = 1'b0; cycle();
        ev_a += int'(a_ev); ev_b += int'(b_ev);
    endtask

    task automatic test_reset();
        RST = 1'b1; PULSE_IN = 1'b1; CLEAR = 1'b0; SNAP_REQ = 1'b0;
        model_reset();
        repeat (3) cycle();
        checks++;
        if ({obs(0), obs(1), obs(2)} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h/%h/%h exp=0", obs(0), obs(1), obs(2));
        end
        RST = 1'b0;
        cycle();
        checks++;
        if (a_cnt !== 16'd1 || a_ev !== 1'b1) begin
            failures++;
            $display("FAIL first_edge_after_reset got cnt=%0d ev=%0b exp cnt=1 ev=1", a_cnt, a_ev);
        end
        repeat (3) cycle();
        checks++;
        if (a_cnt !== 16'd1 || a_ev !== 1'b0) begin
            failures++;
            $display("FAIL held_high_counts_once got cnt=%0d ev=%0b exp cnt=1 ev=0", a_cnt, a_ev);
        end
        PULSE_IN = 1'b0;
        cycle();
    endtask

    task automatic test_stretched_pulse();
        bit pattern[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int events = 0;
        int unsigned base = m_cnt[0];
        for (int k = 0; k < 8; k++) begin
            PULSE_IN = pattern[k];
            cycle();
            events += int'(a_ev);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL stretched_model inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), expv(i));
                end
            end
        end
        checks++;
        if (events != 2 || a_cnt !== 16'(base + 2)) begin
            failures++;
            $display("FAIL stretched_pulse got events=%0d cnt=%0d exp events=2 cnt=%0d", events, a_cnt, base + 2);
        end
    endtask

    task automatic test_saturation();
        int ea, eb, total = 0;
        CLEAR = 1'b1; cycle(); CLEAR = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            pulse_once(ea, eb);
            total += eb;
            if (k == 15) begin
                checks++;
                if (b_cnt !== 4'd15 || b_ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL sat_at_15 got cnt=%0d ovf=%0b exp cnt=15 ovf=0", b_cnt, b_ovf);
                end
            end
            if (k == 16) begin
                checks++;
                if (b_cnt !== 4'd15 || b_ovf !== 1'b1) begin
                    failures++;
                    $display("FAIL sat_at_16 got cnt=%0d ovf=%0b exp cnt=15 ovf=1", b_cnt, b_ovf);
                end
            end
        end
        checks++;
        if (b_cnt !== 4'd15 || b_ovf !== 1'b1 || total != 17 || a_cnt !== 16'd17) begin
            failures++;
            $display("FAIL sat_after_17 got cnt=%0d ovf=%0b events=%0d wide=%0d exp 15/1/17/17",
                     b_cnt, b_ovf, total, a_cnt);
        end
    endtask

    task automatic test_clear();
        int ea, eb;
        CLEAR = 1'b1; cycle(); CLEAR = 1'b0;
        checks++;
        if (b_cnt !== 4'd0 || b_ovf !== 1'b0 || a_cnt !== 16'd0) begin
            failures++;
            $display("FAIL clear_only got bcnt=%0d bovf=%0b acnt=%0d exp 0/0/0", b_cnt, b_ovf, a_cnt);
        end
        repeat (5) pulse_once(ea, eb);
        checks++;
        if (a_cnt !== 16'd5) begin
            failures++;
            $display("FAIL pre_clear_count got=%0d exp=5", a_cnt);
        end
        PULSE_IN = 1'b1; CLEAR = 1'b1;
        cycle();
        checks++;
        if (a_cnt !== 16'd1 || a_ovf !== 1'b0 || a_ev !== 1'b1) begin
            failures++;
            $display("FAIL clear_with_edge got cnt=%0d ovf=%0b ev=%0b exp 1/0/1", a_cnt, a_ovf, a_ev);
        end
        PULSE_IN = 1'b0; CLEAR = 1'b0;
        cycle();
        checks++;
        if (a_ev !== 1'b0 || a_cnt !== 16'd1) begin
            failures++;
            $display("FAIL clear_edge_single got ev=%0b cnt=%0d exp ev=0 cnt=1", a_ev, a_cnt);
        end
    endtask

    task automatic test_snap_with_edge();
        int ea, eb;
        CLEAR = 1'b1; cycle(); CLEAR = 1'b0;
        repeat (7) pulse_once(ea, eb);
        PULSE_IN = 1'b1; SNAP_REQ = 1'b1;
        cycle();
        checks++;
        if (a_snap !== 16'd8 || a_ack !== 1'b1 || a_cnt !== 16'd8 || c_snap !== 16'd7 || c_cnt !== 16'd1) begin
            failures++;
            $display("FAIL snap_with_edge got snap=%0d ack=%0b cnt=%0d csnap=%0d ccnt=%0d exp 8/1/8/7/1",
                     a_snap, a_ack, a_cnt, c_snap, c_cnt);
        end
        PULSE_IN = 1'b0; cycle();
        repeat (2) pulse_once(ea, eb);
        checks++;
        if (a_snap !== 16'd8 || a_cnt !== 16'd10 || a_ack !== 1'b1) begin
            failures++;
            $display("FAIL snap_no_recapture got snap=%0d cnt=%0d ack=%0b exp 8/10/1", a_snap, a_cnt, a_ack);
        end
        SNAP_REQ = 1'b0;
        #1;
        checks++;
        if (a_ack !== 1'b1) begin
            failures++;
            $display("FAIL ack_registered got=%0b exp=1", a_ack);
        end
        cycle();
        checks++;
        if (a_ack !== 1'b0 || b_ack !== 1'b0 || c_ack !== 1'b0) begin
            failures++;
            $display("FAIL ack_release got=%0b%0b%0b exp=000", a_ack, b_ack, c_ack);
        end
    endtask

    task automatic test_clear_on_snap();
        int ea, eb;
        CLEAR = 1'b1; cycle(); CLEAR = 1'b0;
        repeat (10) pulse_once(ea, eb);
        PULSE_IN = 1'b1; SNAP_REQ = 1'b1;
        cycle();
        checks++;
        if (c_snap !== 16'd10 || c_cnt !== 16'd1 || c_ev !== 1'b1) begin
            failures++;
            $display("FAIL cos_first_snap got snap=%0d cnt=%0d ev=%0b exp 10/1/1", c_snap, c_cnt, c_ev);
        end
        PULSE_IN = 1'b0; SNAP_REQ = 1'b0; cycle();
        repeat (3) pulse_once(ea, eb);
        SNAP_REQ = 1'b1;
        cycle();
        checks++;
        if (c_snap !== 16'd4 || c_cnt !== 16'd0 || a_snap !== 16'd14) begin
            failures++;
            $display("FAIL cos_second_snap got snap=%0d cnt=%0d wide_snap=%0d exp 4/0/14", c_snap, c_cnt, a_snap);
        end
        SNAP_REQ = 1'b0; cycle();
    endtask

    task automatic test_reset_mid_handshake();
        int ea, eb;
        CLEAR = 1'b1; cycle(); CLEAR = 1'b0;
        repeat (9) pulse_once(ea, eb);
        SNAP_REQ = 1'b1;
        cycle();
        checks++;
        if (a_ack !== 1'b1 || a_cnt !== 16'd9) begin
            failures++;
            $display("FAIL pre_reset_handshake got ack=%0b cnt=%0d exp 1/9", a_ack, a_cnt);
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({obs(0), obs(1), obs(2)} !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h/%h/%h exp=0", obs(0), obs(1), obs(2));
        end
        model_reset();
        SNAP_REQ = 1'b0;
        cycle();
        RST = 1'b0;
        cycle();
        SNAP_REQ = 1'b1;
        cycle();
        checks++;
        if (a_ack !== 1'b1 || a_snap !== 16'd0) begin
            failures++;
            $display("FAIL rerequest got ack=%0b snap=%0d exp 1/0", a_ack, a_snap);
        end
        SNAP_REQ = 1'b0;
        cycle();
        checks++;
        if (a_ack !== 1'b0) begin
            failures++;
            $display("FAIL rerequest_release got=%0b exp=0", a_ack);
        end
    endtask

    task automatic test_random();
        int cyc_fail = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) PULSE_IN = ~PULSE_IN;
            CLEAR = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 4) == 0) SNAP_REQ = ~SNAP_REQ;
            cycle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    cyc_fail++;
                    if (cyc_fail < 10)
                        $display("FAIL random inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), expv(i));
                end
            end
        end
        PULSE_IN = 1'b0; CLEAR = 1'b0; SNAP_REQ = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_stretched_pulse();
        test_saturation();
        test_clear();
        test_snap_with_edge();
        test_clear_on_snap();
        test_reset_mid_handshake();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_event_counter.md
PULSE_EVENT_COUNTER -- requirements
Module: pulse_event_counter

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16, giving the counter and snapshot width in bits.
REQ-002 The block SHALL have parameter CLEAR_ON_SNAP, default 0; when 1, every snapshot also restarts the counter.
REQ-003 The block SHALL run on one clock and an asynchronous, active-high reset, with all flops on posedge CLK or posedge RST.
REQ-004 CLK  input  1  sole clock; the slow-domain clock that also drives the upstream pulse synchronizer output stage.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 PULSE_IN  input  1  synchronized event from the upstream pulse synchronizer; may stay high for 1..N consecutive CLK cycles per event.
REQ-007 CLEAR  input  1  synchronous clear of COUNT and OVERFLOW, sampled every cycle.
REQ-008 SNAP_REQ  input  1  four-phase snapshot request level.
REQ-009 SNAP_ACK  output  1  four-phase snapshot acknowledge.
REQ-010 SNAP_COUNT  output  CNT_WIDTH  count captured at the last snapshot.
REQ-011 COUNT  output  CNT_WIDTH  live event count.
REQ-012 OVERFLOW  output  1  sticky saturation flag.
REQ-013 EVENT  output  1  one-cycle strobe per counted event.

Function
REQ-014 The block SHALL register PULSE_IN into PULSE_D and define edge = PULSE_IN & ~PULSE_D, so one stretched pulse counts exactly once.
REQ-015 On each edge the block SHALL drive EVENT high for exactly one cycle, on the clock edge following the cycle in which edge is true (latency 1).
REQ-016 On each edge COUNT SHALL increment by 1 on the same clock edge that raises EVENT.
REQ-017 COUNT SHALL saturate at 2^CNT_WIDTH-1, and an edge arriving while COUNT is at maximum SHALL set OVERFLOW and leave COUNT unchanged.
REQ-018 OVERFLOW SHALL stay set until CLEAR or RST.
REQ-019 CLEAR without a concurrent edge SHALL load COUNT=0 and OVERFLOW=0.
REQ-020 CLEAR with a concurrent edge SHALL load COUNT=1 and OVERFLOW=0, and EVENT SHALL still pulse, so no event is lost.
REQ-021 The snapshot FSM SHALL have exactly two states, IDLE and ACK, and SHALL reset to IDLE.
REQ-022 IDLE -> ACK SHALL occur when SNAP_REQ=1; on that edge SNAP_COUNT SHALL load the next COUNT value, including any concurrent edge and concurrent CLEAR.
REQ-023 In ACK, SNAP_ACK SHALL be 1; ACK -> IDLE SHALL occur when SNAP_REQ=0, with SNAP_ACK=0 from the following cycle.
REQ-024 SNAP_REQ held high in ACK SHALL NOT trigger a new capture; a new capture requires returning to IDLE first.
REQ-025 With CLEAR_ON_SNAP=1, the capture edge SHALL also load COUNT=edge?1:0 and clear OVERFLOW, so the events of successive snapshots sum exactly.
REQ-026 With CLEAR_ON_SNAP=1, a concurrent CLEAR SHALL have the same effect as the snapshot clear.
REQ-027 PULSE_IN held high continuously SHALL count exactly once, at its rising edge; PULSE_IN high out of reset SHALL count once, because PULSE_D resets to 0.
REQ-028 SNAP_ACK SHALL be a registered output with no combinational path from SNAP_REQ.

Reset
REQ-029 RST SHALL force PULSE_D=0, EVENT=0, COUNT=0, OVERFLOW=0, SNAP_COUNT=0, SNAP_ACK=0 and FSM=IDLE, immediately and asynchronously.
REQ-030 RST asserted mid-handshake SHALL abort the handshake; the requester SHALL see SNAP_ACK=0 and must re-request.
REQ-031 After RST deasserts, the first edge SHALL be counted on the first CLK posedge at which PULSE_IN=1.

Structure
REQ-032 The FSM state encoding (IDLE, ACK) SHALL be defined as localparams inside the module; no shared package is required.
REQ-033 The edge detect plus EVENT strobe SHALL be a natural sub-module, pulse_edge_detect (ports CLK, RST, LEVEL_IN, EDGE_OUT), reusable after any pulse synchronizer.
REQ-034 Counter, saturation and snapshot logic SHALL remain in pulse_event_counter.

Verification
REQ-035 PULSE_IN high for 3 cycles, low for 2, then high for 1 -> exactly two EVENT strobes, COUNT=2.
REQ-036 CNT_WIDTH=4, 17 separated pulses -> COUNT=15, OVERFLOW=1 after the 16th pulse, EVENT pulsed 17 times.
REQ-037 COUNT=5, CLEAR and an edge in the same cycle -> COUNT=1, OVERFLOW=0, one EVENT.
REQ-038 COUNT=7, SNAP_REQ raised in the same cycle as an edge -> SNAP_COUNT=8, SNAP_ACK=1 the next cycle, SNAP_ACK=0 one cycle after SNAP_REQ falls.
REQ-039 CLEAR_ON_SNAP=1, 10 pulses, snapshot, then 4 pulses, snapshot -> SNAP_COUNT reads 10 then 4, with no event lost at either boundary.
REQ-040 RST pulsed while SNAP_ACK=1 with COUNT=9 -> all outputs 0 immediately, FSM=IDLE, and a new request completes normally.
